// File: rtl/ucsbece154b_hazard_pkg.sv
// Shared encodings for the multi-cycle hazard unit: forwarding selects and
// the multi-cycle tracker state.
package ucsbece154b_hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam int MC_CNT_W = 8;

  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_e;

endpackage

// File: rtl/ucsbece154b_mc_tracker.sv
// Multi-cycle execute tracker: keeps an E-stage op resident for MC_LATENCY
// cycles. The first cycle is spent in IDLE, the rest are counted down in BUSY.
module ucsbece154b_mc_tracker
  import ucsbece154b_hazard_pkg::*;
#(
  parameter int MC_LATENCY = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic multi_i,
  input  logic hold_i,
  output logic mc_stall_o,
  output logic busy_o
);

  localparam bit                  MC_EN    = (MC_LATENCY > 1);
  localparam int                  INIT_INT = (MC_LATENCY > 1) ? MC_LATENCY - 2 : 0;
  localparam logic [MC_CNT_W-1:0] CNT_INIT = MC_CNT_W'(INIT_INT);

  mc_state_e           state_q;
  logic [MC_CNT_W-1:0] cnt_q;

  // The final BUSY cycle (cnt==0) releases the pipeline while the op completes.
  always_comb begin
    mc_stall_o = 1'b0;
    case (state_q)
      MC_IDLE: mc_stall_o = MC_EN && multi_i;
      MC_BUSY: mc_stall_o = (cnt_q != '0);
      default: mc_stall_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MC_IDLE;
      cnt_q   <= '0;
    end else if (!hold_i) begin
      case (state_q)
        MC_IDLE: begin
          if (MC_EN && multi_i) begin
            state_q <= MC_BUSY;
            cnt_q   <= CNT_INIT;
          end
        end
        MC_BUSY: begin
          if (cnt_q == '0) state_q <= MC_IDLE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        default: state_q <= MC_IDLE;
      endcase
    end
  end

  assign busy_o = (state_q == MC_BUSY);

endmodule

// File: rtl/ucsbece154b_hazard_unit_mc.sv
// 5-stage hazard/forwarding unit with multi-cycle E ops and a variable-latency
// data memory. Define HAZARD_PERF_CNT_EN to add saturating stall/flush counters.
module ucsbece154b_hazard_unit_mc
  import ucsbece154b_hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1D_i,
  input  logic [REG_AW-1:0] Rs2D_i,
  input  logic [REG_AW-1:0] Rs1E_i,
  input  logic [REG_AW-1:0] Rs2E_i,
  input  logic [REG_AW-1:0] RdE_i,
  input  logic [REG_AW-1:0] RdM_i,
  input  logic [REG_AW-1:0] RdW_i,
  input  logic              RegWriteM_i,
  input  logic              RegWriteW_i,
  input  logic              LoadE_i,
  input  logic              MultiE_i,
  input  logic              PCSrcE_i,
  input  logic              MemReqM_i,
  input  logic              MemReadyM_i,
  output logic              StallF_o,
  output logic              StallD_o,
  output logic              StallE_o,
  output logic              StallM_o,
  output logic              FlushD_o,
  output logic              FlushE_o,
  output logic              FlushM_o,
  output logic              FlushW_o,
  output logic [1:0]        ForwardAE_o,
  output logic [1:0]        ForwardBE_o,
  output logic              McBusy_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  LuStallCnt_o,
  output logic [CNT_W-1:0]  MemWaitCnt_o,
  output logic [CNT_W-1:0]  FlushCnt_o
`endif
);

  if (MC_LATENCY < 1 || MC_LATENCY > 255 || CNT_W < 1) begin : g_bad_param
    $error("ucsbece154b_hazard_unit_mc: illegal MC_LATENCY or CNT_W");
  end

  // Operand 0 is A (Rs1E), operand 1 is B (Rs2E); M beats W.
  logic [1:0][REG_AW-1:0] rs_e;
  logic [1:0][1:0]        fwd;

  assign rs_e = {Rs2E_i, Rs1E_i};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    logic hit_m, hit_w;
    assign hit_m  = (rs_e[g] != '0) && (rs_e[g] == RdM_i) && RegWriteM_i;
    assign hit_w  = (rs_e[g] != '0) && (rs_e[g] == RdW_i) && RegWriteW_i;
    assign fwd[g] = hit_m ? FWD_M : (hit_w ? FWD_W : FWD_RF);
  end

  assign ForwardAE_o = fwd[0];
  assign ForwardBE_o = fwd[1];

  logic mem_stall, lw_stall, mc_stall;

  assign mem_stall = MemReqM_i & ~MemReadyM_i;
  assign lw_stall  = LoadE_i & (RdE_i != '0) & ((RdE_i == Rs1D_i) | (RdE_i == Rs2D_i));

  ucsbece154b_mc_tracker #(
    .MC_LATENCY(MC_LATENCY)
  ) u_mc (
    .clk       (clk),
    .reset     (reset),
    .multi_i   (MultiE_i),
    .hold_i    (mem_stall),
    .mc_stall_o(mc_stall),
    .busy_o    (McBusy_o)
  );

  // A waiting memory freezes everything upstream and bubbles W; it overrides
  // redirects so a branch resolved during the wait is re-seen afterwards.
  assign StallF_o = reset & (mem_stall | lw_stall | mc_stall);
  assign StallD_o = reset & (mem_stall | lw_stall | mc_stall);
  assign StallE_o = reset & (mem_stall | mc_stall);
  assign StallM_o = reset & mem_stall;
  assign FlushD_o = reset & PCSrcE_i & ~mem_stall;
  assign FlushE_o = reset & (PCSrcE_i | lw_stall) & ~mem_stall & ~mc_stall;
  assign FlushM_o = reset & mc_stall & ~mem_stall;
  assign FlushW_o = reset & mem_stall;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] lu_cnt_q, mem_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lu_cnt_q    <= '0;
      mem_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (lw_stall  && ~&lu_cnt_q)    lu_cnt_q    <= lu_cnt_q + 1'b1;
      if (mem_stall && ~&mem_cnt_q)   mem_cnt_q   <= mem_cnt_q + 1'b1;
      if (FlushD_o  && ~&flush_cnt_q) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign LuStallCnt_o = lu_cnt_q;
  assign MemWaitCnt_o = mem_cnt_q;
  assign FlushCnt_o   = flush_cnt_q;
`endif

`ifdef SIM
  a_e_onehot: assert property (@(posedge clk) disable iff (!reset)
    $onehot0({LoadE_i, MultiE_i, PCSrcE_i}));
`endif

endmodule

// File: tb/tb_ucsbece154b_hazard_unit_mc.sv
// Bench for ucsbece154b_hazard_unit_mc: combinational vector table plus
// multi-cycle sequences; a latency-1 instance runs on the same inputs.
module tb_ucsbece154b_hazard_unit_mc;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       rwm, rww, lde, mle, pcs, mrq, mrd;
  } in_t;

  // stall = {F,D,E,M}, flush = {D,E,M,W}; l1 = {stall,flush,busy} of the latency-1 DUT
  typedef struct packed {
    logic [3:0] stall;
    logic [3:0] flush;
    logic [1:0] fa, fb;
    logic       busy;
    logic [8:0] l1;
  } exp_t;

  typedef struct {
    string name;
    in_t   i;
    exp_t  e;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteM, RegWriteW, LoadE, MultiE, PCSrcE, MemReqM, MemReadyM;

  logic sF, sD, sE, sM, fD, fE, fM, fW, busy;
  logic [1:0] fa, fb;
  logic s1F, s1D, s1E, s1M, f1D, f1E, f1M, f1W, busy1;
  logic [1:0] fa1, fb1;

  always #5 clk = ~clk;

  ucsbece154b_hazard_unit_mc #(.REG_AW(5), .MC_LATENCY(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .Rs1D_i(Rs1D), .Rs2D_i(Rs2D), .Rs1E_i(Rs1E), .Rs2E_i(Rs2E), .RdE_i(RdE),
    .RdM_i(RdM), .RdW_i(RdW), .RegWriteM_i(RegWriteM), .RegWriteW_i(RegWriteW),
    .LoadE_i(LoadE), .MultiE_i(MultiE), .PCSrcE_i(PCSrcE),
    .MemReqM_i(MemReqM), .MemReadyM_i(MemReadyM),
    .StallF_o(sF), .StallD_o(sD), .StallE_o(sE), .StallM_o(sM),
    .FlushD_o(fD), .FlushE_o(fE), .FlushM_o(fM), .FlushW_o(fW),
    .ForwardAE_o(fa), .ForwardBE_o(fb), .McBusy_o(busy)
  );

  ucsbece154b_hazard_unit_mc #(.REG_AW(5), .MC_LATENCY(1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset),
    .Rs1D_i(Rs1D), .Rs2D_i(Rs2D), .Rs1E_i(Rs1E), .Rs2E_i(Rs2E), .RdE_i(RdE),
    .RdM_i(RdM), .RdW_i(RdW), .RegWriteM_i(RegWriteM), .RegWriteW_i(RegWriteW),
    .LoadE_i(LoadE), .MultiE_i(MultiE), .PCSrcE_i(PCSrcE),
    .MemReqM_i(MemReqM), .MemReadyM_i(MemReadyM),
    .StallF_o(s1F), .StallD_o(s1D), .StallE_o(s1E), .StallM_o(s1M),
    .FlushD_o(f1D), .FlushE_o(f1E), .FlushM_o(f1M), .FlushW_o(f1W),
    .ForwardAE_o(fa1), .ForwardBE_o(fb1), .McBusy_o(busy1)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  vec_t tv[$];

  function automatic exp_t exs(logic [3:0] s, logic [3:0] f, logic [1:0] a, logic [1:0] b);
    exp_t e;
    e.stall = s; e.flush = f; e.fa = a; e.fb = b; e.busy = 1'b0;
    e.l1 = {s, f, 1'b0};
    return e;
  endfunction

  function automatic exp_t exm(logic [3:0] s, logic [3:0] f, logic bz, logic [3:0] s1, logic [3:0] f1);
    exp_t e;
    e.stall = s; e.flush = f; e.fa = 2'b00; e.fb = 2'b00; e.busy = bz;
    e.l1 = {s1, f1, 1'b0};
    return e;
  endfunction

  task automatic add(input string n, input in_t i, input exp_t e);
    vec_t v;
    v.name = n; v.i = i; v.e = e;
    tv.push_back(v);
  endtask

  task automatic apply(input in_t v);
    reset = v.rst;
    Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e;
    RdE = v.rde; RdM = v.rdm; RdW = v.rdw;
    RegWriteM = v.rwm; RegWriteW = v.rww; LoadE = v.lde; MultiE = v.mle;
    PCSrcE = v.pcs; MemReqM = v.mrq; MemReadyM = v.mrd;
  endtask

  // Drive, queue the expectation, compare at the falling edge, then let the clock tick.
  task automatic step(input string n, input in_t v, input exp_t e);
    exp_t x;
    logic [12:0] act, req;
    logic [8:0]  act1;
    apply(v);
    sb.push_back(e);
    @(negedge clk);
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty", n);
    end else begin
      x    = sb.pop_front();
      act  = {sF, sD, sE, sM, fD, fE, fM, fW, fa, fb, busy};
      req  = {x.stall, x.flush, x.fa, x.fb, x.busy};
      act1 = {s1F, s1D, s1E, s1M, f1D, f1E, f1M, f1W, busy1};
      if (act !== req || act1 !== x.l1) begin
        n_fail++;
        $display("FAIL %s: got stall/flush/fa/fb/busy=%b l1=%b, expected %b l1=%b",
                 n, act, act1, req, x.l1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_t idle, mc, mem, mcrst;
    idle  = '{rst: 1'b1, default: '0};
    mc    = '{rst: 1'b1, mle: 1'b1, default: '0};
    mem   = '{rst: 1'b1, mle: 1'b1, mrq: 1'b1, default: '0};
    mcrst = '{rst: 1'b0, mle: 1'b1, default: '0};

    add("reset_gates", '{rst: 1'b0, pcs: 1'b1, mrq: 1'b1, rs1e: 5'd5, rdm: 5'd5, rwm: 1'b1, default: '0},
        exs(4'b0000, 4'b0000, 2'b10, 2'b00));
    add("fwdA_M", '{rst: 1'b1, rs1e: 5'd5, rdm: 5'd5, rwm: 1'b1, rdw: 5'd5, rww: 1'b1, default: '0},
        exs(4'b0000, 4'b0000, 2'b10, 2'b00));
    add("fwdA_W", '{rst: 1'b1, rs1e: 5'd5, rdm: 5'd5, rdw: 5'd5, rww: 1'b1, default: '0},
        exs(4'b0000, 4'b0000, 2'b01, 2'b00));
    add("fwdA_x0", '{rst: 1'b1, rdm: 5'd5, rdw: 5'd5, rww: 1'b1, default: '0},
        exs(4'b0000, 4'b0000, 2'b00, 2'b00));
    add("fwd_AW_BM", '{rst: 1'b1, rs1e: 5'd3, rs2e: 5'd9, rdm: 5'd9, rwm: 1'b1, rdw: 5'd3, rww: 1'b1, default: '0},
        exs(4'b0000, 4'b0000, 2'b01, 2'b10));
    add("fwd_rd0", '{rst: 1'b1, rwm: 1'b1, rww: 1'b1, default: '0},
        exs(4'b0000, 4'b0000, 2'b00, 2'b00));
    add("lw_rs2", '{rst: 1'b1, lde: 1'b1, rde: 5'd7, rs2d: 5'd7, default: '0},
        exs(4'b1100, 4'b0100, 2'b00, 2'b00));
    add("lw_rd0", '{rst: 1'b1, lde: 1'b1, default: '0},
        exs(4'b0000, 4'b0000, 2'b00, 2'b00));
    add("lw_rs1", '{rst: 1'b1, lde: 1'b1, rde: 5'd7, rs1d: 5'd7, default: '0},
        exs(4'b1100, 4'b0100, 2'b00, 2'b00));
    add("noload", '{rst: 1'b1, rde: 5'd7, rs1d: 5'd7, default: '0},
        exs(4'b0000, 4'b0000, 2'b00, 2'b00));
    add("branch", '{rst: 1'b1, pcs: 1'b1, default: '0},
        exs(4'b0000, 4'b1100, 2'b00, 2'b00));
    add("branch_memwait", '{rst: 1'b1, pcs: 1'b1, mrq: 1'b1, default: '0},
        exs(4'b1111, 4'b0001, 2'b00, 2'b00));
    add("branch_memready", '{rst: 1'b1, pcs: 1'b1, mrq: 1'b1, mrd: 1'b1, default: '0},
        exs(4'b0000, 4'b1100, 2'b00, 2'b00));
    add("ready_noreq", '{rst: 1'b1, mrd: 1'b1, default: '0},
        exs(4'b0000, 4'b0000, 2'b00, 2'b00));
    add("lw_memwait", '{rst: 1'b1, lde: 1'b1, rde: 5'd7, rs2d: 5'd7, mrq: 1'b1, default: '0},
        exs(4'b1111, 4'b0001, 2'b00, 2'b00));

    apply('{rst: 1'b0, default: '0});
    @(posedge clk);
    #1;
    foreach (tv[k]) step(tv[k].name, tv[k].i, tv[k].e);

    // Single multi-cycle op: stalls cycles 1-3, busy cycles 2-4.
    for (int c = 1; c <= 4; c++)
      step($sformatf("mc4_c%0d", c), mc,
           (c < 4) ? exm(4'b1110, 4'b0010, c > 1, 4'b0000, 4'b0000)
                   : exm(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000));
    step("mc4_idle", idle, exm(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000));

    // Two ops back to back, no gap between them.
    for (int c = 1; c <= 8; c++)
      step($sformatf("b2b_c%0d", c), mc,
           ((c % 4) != 0) ? exm(4'b1110, 4'b0010, (c % 4) != 1, 4'b0000, 4'b0000)
                          : exm(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000));
    step("b2b_idle", idle, exm(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000));

    // Memory wait of 3 cycles while BUSY with cnt=1: residence grows to 7.
    step("mw_c1", mc, exm(4'b1110, 4'b0010, 1'b0, 4'b0000, 4'b0000));
    step("mw_c2", mc, exm(4'b1110, 4'b0010, 1'b1, 4'b0000, 4'b0000));
    for (int c = 3; c <= 5; c++)
      step($sformatf("mw_c%0d", c), mem, exm(4'b1111, 4'b0001, 1'b1, 4'b1111, 4'b0001));
    step("mw_c6", mc, exm(4'b1110, 4'b0010, 1'b1, 4'b0000, 4'b0000));
    step("mw_c7", mc, exm(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000));
    step("mw_idle", idle, exm(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000));

    // Reset dropped while BUSY with cnt=1, then a fresh op.
    step("rst_c1", mc, exm(4'b1110, 4'b0010, 1'b0, 4'b0000, 4'b0000));
    step("rst_c2", mc, exm(4'b1110, 4'b0010, 1'b1, 4'b0000, 4'b0000));
    step("rst_mid", mcrst, exm(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000));
    for (int c = 1; c <= 4; c++)
      step($sformatf("fresh_c%0d", c), mc,
           (c < 4) ? exm(4'b1110, 4'b0010, c > 1, 4'b0000, 4'b0000)
                   : exm(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000));
    step("fresh_idle", idle, exm(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ucsbece154b_hazard_unit_mc.md
Name: ucsbece154b_hazard_unit_mc

Overview:
Parametrised hazard, stall and forwarding unit for the 5-stage RISC-V pipeline (F/D/E/M/W). It adds two stall sources to the load-use/branch-flush scheme:
- a multi-cycle execute unit, where an op occupies E for MC_LATENCY cycles;
- a variable-latency data memory, using a MemReq/MemReady handshake in M.

It drives per-stage stall and flush controls and the E-stage operand forwarding selects.

Parameters:
REG_AW, 5, register index width
MC_LATENCY, 4, total cycles a multi-cycle op spends in E; legal range 1..255
CNT_W, 16, width of the performance counters (optional feature only)

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-low reset
Rs1D_i, Rs2D_i  in  REG_AW  source registers in D
Rs1E_i, Rs2E_i, RdE_i  in  REG_AW  source and destination registers in E
RdM_i, RdW_i  in  REG_AW  destination registers in M and W
RegWriteM_i, RegWriteW_i  in  1  register write enable in M and W
LoadE_i  in  1  instruction in E is a load
MultiE_i  in  1  instruction in E is multi-cycle
PCSrcE_i  in  1  taken branch or jump resolved in E
MemReqM_i  in  1  M-stage memory access active
MemReadyM_i  in  1  memory completes the access this cycle
StallF_o, StallD_o, StallE_o, StallM_o  out  1  hold the stage register
FlushD_o, FlushE_o, FlushM_o, FlushW_o  out  1  insert a bubble into the stage register
ForwardAE_o, ForwardBE_o  out  2  operand select: 00 = register file, 01 = W result, 10 = M ALU result
McBusy_o  out  1  multi-cycle FSM is in BUSY

Behaviour:
- Forwarding (combinational), for A (Rs1E) and B (Rs2E):
  - 10 if Rs!=0 and Rs==RdM_i and RegWriteM_i.
  - Otherwise 01 if Rs!=0 and Rs==RdW_i and RegWriteW_i.
  - Otherwise 00.
  - M has priority over W.
- memStall = MemReqM_i & ~MemReadyM_i.
  - Forces StallF/D/E/M=1 and FlushW=1.
  - Forces all other flushes to 0 and PCSrcE is ignored.
  - The multi-cycle FSM and its counter hold.
- lwStall = LoadE_i & RdE_i!=0 & (RdE_i==Rs1D_i | RdE_i==Rs2D_i).
  - Effect: StallF=StallD=1, FlushE=1.
- Multi-cycle FSM (states IDLE, BUSY; 8-bit counter cnt). Transitions apply only when memStall=0.
  - IDLE with MultiE_i=1 and MC_LATENCY>1: mcStall=1; go to BUSY with cnt=MC_LATENCY-2.
  - BUSY with cnt!=0: mcStall=1; cnt decrements.
  - BUSY with cnt==0: mcStall=0; go to IDLE.
  - Result: the op occupies E for exactly MC_LATENCY cycles. Back-to-back multi-cycle ops each take MC_LATENCY cycles with no gap.
  - MC_LATENCY=1: the FSM never leaves IDLE and produces no stall.
  - Effect of mcStall: StallF=StallD=StallE=1, FlushM=1.
- FlushD = PCSrcE_i & ~memStall.
- FlushE = (PCSrcE_i | lwStall) & ~memStall & ~mcStall.
- Mutual exclusions: LoadE_i, MultiE_i and PCSrcE_i describe one E instruction and are mutually exclusive. More than one of them high is illegal; flag it with an assertion under SIM.
- Reset (async, active-low, legal mid-operation):
  - FSM to IDLE, cnt=0, McBusy_o=0.
  - While reset is low, all stall and flush outputs are 0.
  - Forwarding outputs stay purely combinational.
- All outputs except McBusy_o are combinational. Stall/flush decisions take effect at the next rising clk edge.

Optional Feature:
HAZARD_PERF_CNT_EN:
- When defined, adds three outputs, each CNT_W wide and saturating at all-ones:
  - LuStallCnt_o: increments each cycle lwStall causes a stall.
  - MemWaitCnt_o: increments each cycle memStall is high.
  - FlushCnt_o: increments each cycle FlushD_o is high.
- Counters reset to 0 on reset.
- When undefined, these ports and registers do not exist, and the remaining behaviour is identical.

Decomposition:
- Shared package (ucsbece154b_hazard_pkg):
  - Forward encodings FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - FSM state constants MC_IDLE and MC_BUSY.
- One sub-module, ucsbece154b_mc_tracker:
  - Contains the multi-cycle FSM and counter.
  - Inputs: MultiE, hold (=memStall).
  - Outputs: mcStall, busy.

Test Plan:
1. Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10. Set RegWriteM=0 -> ForwardAE=01. Set Rs1E=0 -> ForwardAE=00.
2. LoadE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle. Repeat with RdE=0 -> no stall.
3. MC_LATENCY=4, MultiE=1 held for 4 cycles -> mcStall high cycles 1-3, low in cycle 4, FlushM=1 in cycles 1-3, McBusy high cycles 2-4. Repeat with MC_LATENCY=1 -> no stall.
4. MemReqM=1, MemReadyM=0 for 3 cycles during BUSY -> StallF/D/E/M=1 and FlushW=1 for 3 cycles, cnt frozen, total multi-cycle residence extended by 3 cycles.
5. PCSrcE=1 -> FlushD=FlushE=1. Same with memStall=1 -> both flushes 0 until MemReadyM=1.
6. Assert reset low during BUSY with cnt=1 -> McBusy=0 immediately, all stall and flush outputs 0; after release, MultiE=1 starts a fresh MC_LATENCY count.
